// File: rtl/button_conditioner_pkg.sv
// Shared types and 25 MHz timing defaults
// for the Connect Four button input stage.
package input_pkg;

  localparam int CLK_HZ = 25_000_000;

  // 10 ms, 500 ms, 150 ms at 25 MHz
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF   = (CLK_HZ / 20) * 3;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    LOCKED
  } move_state_e;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw buttons in, conditioned game pulses out.
// master drives the buttons, slave is the conditioner.
interface button_conditioner_if;

  logic btn_right_raw;
  logic btn_left_raw;
  logic btn_drop_raw;
  logic move_right;
  logic move_left;
  logic drop_piece;

  modport master (
    output btn_right_raw,
    output btn_left_raw,
    output btn_drop_raw,
    input  move_right,
    input  move_left,
    input  drop_piece
  );

  modport slave (
    input  btn_right_raw,
    input  btn_left_raw,
    input  btn_drop_raw,
    output move_right,
    output move_left,
    output drop_piece
  );

endinterface

// File: rtl/button_conditioner_debouncer.sv
// Two-flop synchroniser plus counter debouncer.
// o_level and o_rise are aligned (both one flop late).
module button_debouncer
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = cw(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level_d;
  assign o_rise  = r_rise;

endmodule

// File: rtl/button_conditioner.sv
// Debounced move/drop pulses with hold-to-repeat,
// left+right lockout and one-hot output arbitration.
module button_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input logic           clk_25MHz,
  input logic           rst,
  button_conditioner_if.slave bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cw(RMAX);
  localparam logic [RW-1:0] RD1 = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP1 = RW'(REPEAT_PERIOD - 1);

  // index 0 = right, 1 = left, 2 = drop
  logic [2:0]    w_raw;
  logic [2:0]    w_lvl;
  logic [2:0]    w_rise;

  move_state_e   r_st     [2];
  move_state_e   w_nx     [2];
  logic [RW-1:0] r_cnt    [2];
  logic [RW-1:0] w_cnt_nx [2];
  logic [1:0]    w_req;
  logic [1:0]    w_want;
  logic [1:0]    r_pend;
  logic          w_both;
  logic          w_drop;
  logic          r_mr;
  logic          r_ml;
  logic          r_dp;

  assign w_raw = {bus.btn_drop_raw,
                  bus.btn_left_raw,
                  bus.btn_right_raw};

  for (genvar g = 0; g < 3; g++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_25MHz(clk_25MHz),
      .rst      (rst),
      .i_raw    (w_raw[g]),
      .o_level  (w_lvl[g]),
      .o_rise   (w_rise[g])
    );
  end

  assign w_both = w_lvl[0] & w_lvl[1];
  assign w_drop = w_rise[2] & w_lvl[2];

  always_comb begin
    w_req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_nx[i]     = r_st[i];
      w_cnt_nx[i] = r_cnt[i];
      if (w_both) begin
        w_nx[i] = LOCKED;
      end else begin
        unique case (r_st[i])
          IDLE: begin
            if (w_rise[i]) begin
              w_req[i]    = 1'b1;
              w_nx[i]     = DELAY;
              w_cnt_nx[i] = RD1;
            end
          end
          DELAY, REPEAT: begin
            if (!w_lvl[i]) begin
              w_nx[i] = IDLE;
            end else if (r_cnt[i] == '0) begin
              w_req[i]    = 1'b1;
              w_nx[i]     = REPEAT;
              w_cnt_nx[i] = RP1;
            end else begin
              w_cnt_nx[i] = r_cnt[i] - RW'(1);
            end
          end
          LOCKED: begin
            if (!w_lvl[i]) w_nx[i] = IDLE;
          end
        endcase
      end
    end
    // lockout also kills any deferred pulse
    w_want = (w_req | r_pend) & {2{~w_both}};
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= IDLE;
        r_cnt[i] <= '0;
      end
      r_pend <= 2'b00;
      r_mr   <= 1'b0;
      r_ml   <= 1'b0;
      r_dp   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= w_nx[i];
        r_cnt[i] <= w_cnt_nx[i];
      end
      r_dp <= w_drop;
      if (w_drop) begin
        r_mr   <= 1'b0;
        r_ml   <= 1'b0;
        r_pend <= w_want;
      end else if (w_want[0]) begin
        r_mr   <= 1'b1;
        r_ml   <= 1'b0;
        r_pend <= {w_want[1], 1'b0};
      end else begin
        r_mr   <= 1'b0;
        r_ml   <= w_want[1];
        r_pend <= 2'b00;
      end
    end
  end

  assign bus.move_right = r_mr;
  assign bus.move_left  = r_ml;
  assign bus.drop_piece = r_dp;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed sequences,
// a vector table, and random traffic vs a reference model.
module tb_button_conditioner;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int MAXC = 8192;

  logic clk_25MHz = 1'b0;
  logic rst       = 1'b1;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_25MHz(clk_25MHz),
    .rst      (rst),
    .bus      (bus)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  int cyc     = 3;

  // per-edge history of effective samples and debounced levels
  bit samp [3][MAXC];
  bit lvlh [3][MAXC];
  int run  [3];
  bit lvl  [3];

  bit locked [2];
  bit active [2];
  bit pend   [2];
  int tp     [2];
  bit e_mr, e_ml, e_dp;

  int q_mr [$];
  int q_ml [$];
  int q_dp [$];

  typedef struct {
    bit    br;
    bit    bl;
    bit    bd;
    int    n;
    int    emr;
    int    eml;
    int    edp;
    string nm;
  } vec_t;

  task automatic model(input bit r, input bit br,
                       input bit bl, input bit bd);
    int k;
    int d;
    bit raw  [3];
    bit el   [3];
    bit rs   [3];
    bit req  [2];
    bit want [2];
    bit both;
    k = cyc;
    raw[0] = br;
    raw[1] = bl;
    raw[2] = bd;
    e_mr = 1'b0;
    e_ml = 1'b0;
    e_dp = 1'b0;
    if (r) begin
      for (int b = 0; b < 3; b++) begin
        samp[b][k]   = 1'b0;
        samp[b][k-1] = 1'b0;
        lvlh[b][k]   = 1'b0;
        lvlh[b][k-1] = 1'b0;
        run[b] = 0;
        lvl[b] = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        locked[m] = 1'b0;
        active[m] = 1'b0;
        pend[m]   = 1'b0;
      end
      return;
    end
    // level flips after D consecutive differing samples
    for (int b = 0; b < 3; b++) begin
      samp[b][k] = raw[b];
      if (samp[b][k-2] != lvl[b]) begin
        run[b]++;
        if (run[b] == D) begin
          lvl[b] = !lvl[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
      lvlh[b][k] = lvl[b];
      el[b] = lvlh[b][k-2];
      rs[b] = lvlh[b][k-2] & !lvlh[b][k-3];
    end
    both = el[0] & el[1];
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0;
      if (both) begin
        locked[m] = 1'b1;
        active[m] = 1'b0;
        pend[m]   = 1'b0;
      end else if (locked[m]) begin
        if (!el[m]) locked[m] = 1'b0;
      end else if (active[m]) begin
        if (!el[m]) begin
          active[m] = 1'b0;
        end else begin
          d = k - tp[m];
          if (d == RD || (d > RD && (d - RD) % RP == 0))
            req[m] = 1'b1;
        end
      end else if (rs[m]) begin
        active[m] = 1'b1;
        tp[m]     = k;
        req[m]    = 1'b1;
      end
      want[m] = req[m] | pend[m];
    end
    e_dp = rs[2];
    if (rs[2]) begin
      pend[0] = want[0];
      pend[1] = want[1];
    end else if (want[0]) begin
      e_mr    = 1'b1;
      pend[0] = 1'b0;
      pend[1] = want[1];
    end else begin
      e_ml    = want[1];
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end
  endtask

  task automatic tick(input bit r, input bit br,
                      input bit bl, input bit bd);
    bus.btn_right_raw = br;
    bus.btn_left_raw  = bl;
    bus.btn_drop_raw  = bd;
    rst = r;
    @(posedge clk_25MHz);
    cyc++;
    model(r, br, bl, bd);
    @(negedge clk_25MHz);
    n_tests++;
    if ({bus.move_right, bus.move_left, bus.drop_piece}
        !== {e_mr, e_ml, e_dp}) begin
      n_fail++;
      if (n_print < 30)
        $display("FAIL model cyc=%0d got=%b%b%b exp=%b%b%b",
                 cyc, bus.move_right, bus.move_left,
                 bus.drop_piece, e_mr, e_ml, e_dp);
      n_print++;
    end
    n_tests++;
    if (int'(bus.move_right) + int'(bus.move_left)
        + int'(bus.drop_piece) > 1) begin
      n_fail++;
      if (n_print < 30)
        $display("FAIL onehot cyc=%0d got=%b%b%b exp=at most one",
                 cyc, bus.move_right, bus.move_left,
                 bus.drop_piece);
      n_print++;
    end
    if (bus.move_right === 1'b1) q_mr.push_back(cyc);
    if (bus.move_left  === 1'b1) q_ml.push_back(cyc);
    if (bus.drop_piece === 1'b1) q_dp.push_back(cyc);
  endtask

  task automatic hold(input bit r, input bit br, input bit bl,
                      input bit bd, input int n);
    repeat (n) tick(r, br, bl, bd);
  endtask

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic clrq();
    q_mr.delete();
    q_ml.delete();
    q_dp.delete();
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    int   offs [6];
    int   p;
    int   hl  [3];
    bit   val [3];
    bit   rr;

    vt = '{
      '{0, 0, 1, 100, 0, 0, 1, "drop_hold"},
      '{0, 0, 0, 12,  0, 0, 0, "drop_rel"},
      '{0, 0, 1, 10,  0, 0, 1, "drop_again"},
      '{0, 0, 0, 12,  0, 0, 0, "idle_a"},
      '{0, 1, 0, 12,  0, 1, 0, "lk_left"},
      '{1, 1, 0, 30,  0, 0, 0, "lk_both"},
      '{0, 1, 0, 30,  0, 0, 0, "lk_rrel"},
      '{0, 0, 0, 12,  0, 0, 0, "lk_lrel"},
      '{0, 1, 0, 12,  0, 1, 0, "lk_repress"},
      '{0, 0, 0, 12,  0, 0, 0, "idle_b"}
    };
    offs = '{0, 20, 28, 36, 44, 52};

    // reset with every button held
    clrq();
    hold(1, 1, 1, 1, 5);
    chk("rst_out", int'(bus.move_right | bus.move_left
                        | bus.drop_piece), 0);
    chk("rst_cnt", q_mr.size() + q_ml.size() + q_dp.size(), 0);
    clrq();
    p = cyc + 1;
    hold(0, 1, 1, 1, 15);
    chk("rst_dp_n", q_dp.size(), 1);
    if (q_dp.size() > 0) chk("rst_dp_t", q_dp[0], p + 7);
    chk("rst_mr_n", q_mr.size(), 0);
    chk("rst_ml_n", q_ml.size(), 0);
    hold(0, 0, 0, 0, 12);

    // bounce then steady press
    clrq();
    for (int i = 0; i < 20; i++)
      tick(0, ((i / 2) % 2) == 0, 0, 0);
    chk("bnc_quiet", q_mr.size(), 0);
    p = cyc + 1;
    hold(0, 1, 0, 0, 10);
    chk("bnc_n", q_mr.size(), 1);
    if (q_mr.size() > 0) chk("bnc_t", q_mr[0], p + 7);
    hold(0, 0, 0, 0, 12);

    // hold-to-repeat schedule
    clrq();
    p = cyc + 1;
    hold(0, 1, 0, 0, 60);
    hold(0, 0, 0, 0, 40);
    chk("rep_n", q_mr.size(), 6);
    for (int i = 0; i < 6 && i < q_mr.size(); i++)
      chk($sformatf("rep_t%0d", i), q_mr[i], p + 7 + offs[i]);
    chk("rep_ml", q_ml.size(), 0);

    // drop and lockout vector table
    for (int v = 0; v < 10; v++) begin
      clrq();
      hold(0, vt[v].br, vt[v].bl, vt[v].bd, vt[v].n);
      chk({vt[v].nm, "_mr"}, q_mr.size(), vt[v].emr);
      chk({vt[v].nm, "_ml"}, q_ml.size(), vt[v].eml);
      chk({vt[v].nm, "_dp"}, q_dp.size(), vt[v].edp);
    end

    // drop collides with right, then reset in DELAY
    clrq();
    p = cyc + 1;
    hold(0, 1, 0, 1, 10);
    hold(1, 0, 0, 0, 3);
    chk("col_rst_out", int'(bus.move_right | bus.move_left
                            | bus.drop_piece), 0);
    hold(0, 0, 0, 0, 30);
    chk("col_dp_n", q_dp.size(), 1);
    if (q_dp.size() > 0) chk("col_dp_t", q_dp[0], p + 7);
    chk("col_mr_n", q_mr.size(), 1);
    if (q_mr.size() > 0) chk("col_mr_t", q_mr[0], p + 8);
    chk("col_ml_n", q_ml.size(), 0);

    // random traffic with bounces and rare resets
    for (int b = 0; b < 3; b++) begin
      hl[b]  = 0;
      val[b] = 1'b0;
    end
    repeat (2500) begin
      for (int b = 0; b < 3; b++) begin
        if (hl[b] == 0) begin
          val[b] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0)
            hl[b] = int'($urandom_range(1, 3));
          else
            hl[b] = int'($urandom_range(5, 60));
        end
        hl[b]--;
      end
      rr = ($urandom_range(0, 599) == 0);
      tick(rr, val[0], val[1], val[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the Connect Four game, running in the 25 MHz pixel-clock domain.
- Takes three raw, bouncing, asynchronous push-buttons and produces clean single-cycle move_right / move_left / drop_piece pulses for the game logic.
- Adds hold-to-repeat on the two move buttons, a left+right conflict lockout, and mutual exclusion of output pulses.

Parameters:
- DEBOUNCE_CYCLES, 250000: cycles the synchronised input must be stable before the debounced level changes (10 ms).
- REPEAT_DELAY, 12500000: cycles from the initial move pulse to the first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 3750000: cycles between subsequent auto-repeat pulses (150 ms).

Ports:
- clk_25MHz  in  1  pixel clock; the only clock.
- rst  in  1  synchronous active-high reset.
- btn_right_raw  in  1  raw right button, asynchronous, active-high.
- btn_left_raw  in  1  raw left button, asynchronous, active-high.
- btn_drop_raw  in  1  raw drop button, asynchronous, active-high.
- move_right  out  1  one-cycle pulse, registered.
- move_left  out  1  one-cycle pulse, registered.
- drop_piece  out  1  one-cycle pulse, registered.

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising edge of clk_25MHz.
  - Clears all synchroniser flops, debounced levels, counters, pending flags and FSMs (to IDLE).
  - All outputs are 0 while rst=1 and in the first cycle after release.
  - Reset mid-hold or mid-repeat discards all progress.
  - A button still held after reset release is treated as a fresh press and produces a pulse after full debounce.
- Synchroniser: 2-flop per input; no logic is applied to raw inputs.
- Debounce, per button:
  - Counter is cleared whenever sync == level.
  - Counter increments while sync != level.
  - When the counter reaches DEBOUNCE_CYCLES-1, level toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Press event:
  - Issued on a level 0->1 transition.
  - Latency from the first edge sampling a stable-high raw input to the output pulse: DEBOUNCE_CYCLES+3 edges.
- drop_piece: one pulse per press event; no auto-repeat.
- Move FSM (one per move button); states IDLE, DELAY, REPEAT, LOCKED:
  - IDLE, press event: emit pulse, load repeat counter, go DELAY.
  - DELAY: after REPEAT_DELAY cycles from the initial pulse, emit pulse and go REPEAT.
  - REPEAT: emit a pulse every REPEAT_PERIOD cycles.
  - DELAY or REPEAT, own level falls: go IDLE with no pulse.
  - Any state, both move levels high: go LOCKED with no pulse. LOCKED is entered in the same cycle for both FSMs.
  - LOCKED: exit to IDLE only when own level=0, so the still-held button needs a re-press.
  - A press event on one move button while the other is high goes straight to LOCKED; no pulse.
- Output exclusivity: at most one output is high per cycle.
  - drop_piece has priority.
  - A move pulse coinciding with a drop pulse is held in a 1-deep pending flag per move button and emitted the next cycle.
  - A pending move pulse is cancelled if the FSM enters LOCKED.
  - The repeat counter runs from its original schedule; deferral does not shift later repeats.
- Simultaneous press events of left and right in the same cycle: both go LOCKED; no pulses.

Decomposition:
- Shared package input_pkg holds:
  - the move FSM state enum (IDLE, DELAY, REPEAT, LOCKED);
  - default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD derived from the 25 MHz clock.
- One sub-module: button_debouncer.
  - Contains the 2-flop sync, debounce counter and level register.
  - Outputs the level and a one-cycle rise pulse.
  - Instantiated three times.
- Repeat FSMs, lockout and output arbitration live in button_conditioner.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset: hold rst=1 for 5 cycles with all raw inputs high -> all outputs 0; release -> single move_right pulse is suppressed (right+left both held, LOCKED), drop_piece pulses exactly once 7 edges after release.
- Bounce: btn_right_raw toggles every 2 cycles for 20 cycles, then stays high at edge t -> no pulses during bounce; exactly one move_right pulse at t+7.
- Auto-repeat: hold right after the first pulse at t0 for 60 cycles -> move_right pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; release -> no further pulses.
- Drop: hold btn_drop_raw 100 cycles -> exactly one drop_piece pulse; re-press after release -> second pulse.
- Lockout: hold left (pulse at t0), press right at t0+5 -> no move pulses at all; release right with left held -> still none; release and re-press left -> new move_left pulse.
- Collision: raw drop and right rise on the same edge -> drop_piece at t, move_right at t+1, never both high in one cycle; reset asserted at t+3 during DELAY -> no further pulses, outputs 0.
